// File: rtl/btn_event_decoder_if.sv
// Merged button-event bus between the decoder and its single consumer.
// The decoder drives valid/code/type/overflow. The consumer answers with ready.
interface btn_event_decoder_if #(
    parameter int NUM_BTN = 5
);
    localparam int CODE_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

    logic              evt_valid;
    logic              evt_ready;
    logic [CODE_W-1:0] evt_code;
    logic [1:0]        evt_type;
    logic              evt_overflow;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_type,
        output evt_overflow,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_type,
        input  evt_overflow,
        output evt_ready
    );
endinterface

// File: rtl/btn_event_decoder.sv
// Button event decoder.
// Turns debounced button levels into single-cycle short, long and repeat pulses.
// Every pulse is also merged into one valid/ready event register.
// Optional feature: define BTN_EVT_REPEAT_EN to turn on auto-repeat while a button is held.
// Without it, repeat_pulse stays 0 and REPEAT_CYCLES only affects the counter width.
module btn_event_decoder #(
    parameter int NUM_BTN           = 5,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int REPEAT_CYCLES     = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] short_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse,
    btn_event_decoder_if.master evt
);

    localparam int MAX_CYCLES = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam int CODE_W     = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

    localparam logic [CNT_W-1:0]   LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [NUM_BTN-1:0] BTN_ONE   = NUM_BTN'(1);
`ifdef BTN_EVT_REPEAT_EN
    localparam logic [CNT_W-1:0]   REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } btn_state_e;

    btn_state_e         state_q [NUM_BTN];
    btn_state_e         state_n [NUM_BTN];
    logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
    logic [CNT_W-1:0]   cnt_n   [NUM_BTN];

    logic [NUM_BTN-1:0] short_n;
    logic [NUM_BTN-1:0] long_n;
    logic [NUM_BTN-1:0] repeat_n;
    logic [NUM_BTN-1:0] pulse_any_n;

    logic [CODE_W-1:0]  sel_code;
    logic [1:0]         sel_type;
    logic               multi_hit;
    logic               can_load;

    // Per-button state and counter registers. Reset returns every button to IDLE.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BTN; i++) begin
            if (reset) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_n[i];
                cnt_q[i]   <= cnt_n[i];
            end
        end
    end

    // Per-button press/hold decisions; each button raises at most one pulse per cycle.
    always_comb begin
        short_n  = '0;
        long_n   = '0;
        repeat_n = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_n[i] = state_q[i];
            cnt_n[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (btn_level[i]) begin
                        state_n[i] = PRESS;
                        cnt_n[i]   = '0;
                    end
                end
                PRESS: begin
                    if (!btn_level[i]) begin
                        state_n[i] = IDLE;
                        short_n[i] = 1'b1;
                    end else if (cnt_q[i] == LONG_LAST) begin
                        state_n[i] = HOLD;
                        cnt_n[i]   = '0;
                        long_n[i]  = 1'b1;
                    end else begin
                        cnt_n[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!btn_level[i]) begin
                        state_n[i] = IDLE;
`ifdef BTN_EVT_REPEAT_EN
                    end else if (cnt_q[i] == REPEAT_LAST) begin
                        cnt_n[i]    = '0;
                        repeat_n[i] = 1'b1;
                    end else begin
                        cnt_n[i] = cnt_q[i] + CNT_ONE;
`endif
                    end
                end
                default: begin
                    state_n[i] = IDLE;
                    cnt_n[i]   = '0;
                end
            endcase
        end
    end

    // Registered pulse outputs: each pulse is high in the cycle after its deciding edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            short_pulse  <= '0;
            long_pulse   <= '0;
            repeat_pulse <= '0;
        end else begin
            short_pulse  <= short_n;
            long_pulse   <= long_n;
            repeat_pulse <= repeat_n;
        end
    end

    // Picks the lowest-index button that is pulsing and flags if more than one pulsed.
    always_comb begin
        pulse_any_n = short_n | long_n | repeat_n;
        sel_code    = '0;
        sel_type    = 2'b00;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pulse_any_n[i]) begin
                sel_code = CODE_W'(i);
                if (repeat_n[i]) begin
                    sel_type = 2'b11;
                end else if (long_n[i]) begin
                    sel_type = 2'b10;
                end else begin
                    sel_type = 2'b01;
                end
            end
        end
        multi_hit = |(pulse_any_n & (pulse_any_n - BTN_ONE));
        can_load  = !evt.evt_valid || evt.evt_ready;
    end

    // Event register. A slot that is free, or being drained this cycle, takes the new event.
    // An event that finds the slot blocked is dropped and sets the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt.evt_valid    <= 1'b0;
            evt.evt_code     <= '0;
            evt.evt_type     <= 2'b00;
            evt.evt_overflow <= 1'b0;
        end else if (can_load) begin
            evt.evt_valid <= |pulse_any_n;
            if (|pulse_any_n) begin
                evt.evt_code <= sel_code;
                evt.evt_type <= sel_type;
            end
            if (multi_hit) begin
                evt.evt_overflow <= 1'b1;
            end
        end else if (|pulse_any_n) begin
            evt.evt_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Testbench for btn_event_decoder, built with LONG_PRESS_CYCLES=1000 and REPEAT_CYCLES=300.
// Repeat expectations follow BTN_EVT_REPEAT_EN, so the same bench covers both builds.
module tb_btn_event_decoder;

    localparam int NUM_BTN = 5;
    localparam int LONG_C  = 1000;
    localparam int REP_C   = 300;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] short_pulse;
    logic [NUM_BTN-1:0] long_pulse;
    logic [NUM_BTN-1:0] repeat_pulse;

    btn_event_decoder_if #(.NUM_BTN(NUM_BTN)) evt_if ();

    btn_event_decoder #(
        .NUM_BTN           (NUM_BTN),
        .LONG_PRESS_CYCLES (LONG_C),
        .REPEAT_CYCLES     (REP_C)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_level    (btn_level),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .evt          (evt_if)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Results collected while a press is running
    logic [NUM_BTN-1:0] seen_short;
    logic [NUM_BTN-1:0] seen_long;
    int                 short_at;
    int                 long_at;
    int                 pulse_cycles;
    int                 rep_count;
    int                 rep_at [4];
    logic [1:0]         rep_type;
    logic               first_cap;
    logic [2:0]         first_code;
    logic [1:0]         first_type;

    typedef struct {
        logic [NUM_BTN-1:0] mask;
        int                 len;
        logic [NUM_BTN-1:0] exp_short;
        logic [NUM_BTN-1:0] exp_long;
        logic [2:0]         exp_code;
        logic [1:0]         exp_type;
    } vec_t;

    vec_t vecs [5];

    // Compares one value against the expected value and counts the result
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearCapture();
        seen_short   = '0;
        seen_long    = '0;
        short_at     = -1;
        long_at      = -1;
        pulse_cycles = 0;
        rep_count    = 0;
        for (int j = 0; j < 4; j++) rep_at[j] = -1;
        rep_type     = 2'b00;
        first_cap    = 1'b0;
        first_code   = '0;
        first_type   = 2'b00;
    endtask

    // Records what the DUT shows k cycles after the first edge of the press
    task automatic observe(input int k);
        if (short_pulse != '0) begin
            seen_short = seen_short | short_pulse;
            short_at   = k;
        end
        if (long_pulse != '0) begin
            seen_long = seen_long | long_pulse;
            long_at   = k;
        end
        if (repeat_pulse != '0) begin
            if (rep_count < 4) rep_at[rep_count] = k;
            rep_count++;
            rep_type = evt_if.evt_type;
        end
        if ((short_pulse | long_pulse | repeat_pulse) != '0) pulse_cycles++;
        if (evt_if.evt_valid && !first_cap) begin
            first_cap  = 1'b1;
            first_code = evt_if.evt_code;
            first_type = evt_if.evt_type;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds mask for len sampled edges, then releases it and keeps watching for tail cycles
    task automatic applyStimulus(input logic [NUM_BTN-1:0] mask, input int len, input int tail);
        clearCapture();
        btn_level = mask;
        for (int k = 0; k < len + tail; k++) begin
            tick();
            observe(k);
            if (k == len - 1) btn_level = '0;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{mask: 5'b00001, len: 100,  exp_short: 5'b00001, exp_long: 5'b00000, exp_code: 3'd0, exp_type: 2'b01};
        vecs[1] = '{mask: 5'b01000, len: 10,   exp_short: 5'b01000, exp_long: 5'b00000, exp_code: 3'd3, exp_type: 2'b01};
        vecs[2] = '{mask: 5'b10000, len: 1,    exp_short: 5'b10000, exp_long: 5'b00000, exp_code: 3'd4, exp_type: 2'b01};
        vecs[3] = '{mask: 5'b00010, len: 1000, exp_short: 5'b00010, exp_long: 5'b00000, exp_code: 3'd1, exp_type: 2'b01};
        vecs[4] = '{mask: 5'b00100, len: 1001, exp_short: 5'b00000, exp_long: 5'b00100, exp_code: 3'd2, exp_type: 2'b10};

        reset            = 1'b1;
        btn_level        = '0;
        evt_if.evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_short",    32'(short_pulse),         32'h0);
        checkOutput("rst_long",     32'(long_pulse),          32'h0);
        checkOutput("rst_repeat",   32'(repeat_pulse),        32'h0);
        checkOutput("rst_valid",    32'(evt_if.evt_valid),    32'h0);
        checkOutput("rst_code",     32'(evt_if.evt_code),     32'h0);
        checkOutput("rst_type",     32'(evt_if.evt_type),     32'h0);
        checkOutput("rst_overflow", 32'(evt_if.evt_overflow), 32'h0);
        reset = 1'b0;
        tick();

        // Single-button presses, including both sides of the long threshold
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].mask, vecs[i].len, 5);
            checkOutput($sformatf("vec%0d_short", i),    32'(seen_short),          32'(vecs[i].exp_short));
            checkOutput($sformatf("vec%0d_long", i),     32'(seen_long),           32'(vecs[i].exp_long));
            checkOutput($sformatf("vec%0d_code", i),     32'(first_code),          32'(vecs[i].exp_code));
            checkOutput($sformatf("vec%0d_type", i),     32'(first_type),          32'(vecs[i].exp_type));
            checkOutput($sformatf("vec%0d_npulse", i),   32'(pulse_cycles),        32'd1);
            checkOutput($sformatf("vec%0d_valid", i),    32'(evt_if.evt_valid),    32'h0);
            checkOutput($sformatf("vec%0d_overflow", i), 32'(evt_if.evt_overflow), 32'h0);
            if (vecs[i].exp_short != '0)
                checkOutput($sformatf("vec%0d_short_at", i), 32'(short_at), 32'(vecs[i].len));
            if (vecs[i].exp_long != '0)
                checkOutput($sformatf("vec%0d_long_at", i), 32'(long_at), 32'(LONG_C));
        end

        // Long hold on button 2 for 2000 cycles, then a silent release
        applyStimulus(5'b00100, 2000, 5);
        checkOutput("hold_long",    32'(seen_long),  32'b00100);
        checkOutput("hold_long_at", 32'(long_at),    32'(LONG_C));
        checkOutput("hold_short",   32'(seen_short), 32'h0);
        checkOutput("hold_code",    32'(first_code), 32'd2);
        checkOutput("hold_type",    32'(first_type), 32'b10);
`ifdef BTN_EVT_REPEAT_EN
        checkOutput("hold_rep_cnt", 32'(rep_count),  32'd3);
        checkOutput("hold_rep0_at", 32'(rep_at[0]),  32'(LONG_C + REP_C));
        checkOutput("hold_rep1_at", 32'(rep_at[1]),  32'(LONG_C + 2 * REP_C));
        checkOutput("hold_rep2_at", 32'(rep_at[2]),  32'(LONG_C + 3 * REP_C));
        checkOutput("hold_rep_type", 32'(rep_type),  32'b11);
`else
        checkOutput("hold_rep_cnt", 32'(rep_count),  32'd0);
`endif
        checkOutput("hold_overflow", 32'(evt_if.evt_overflow), 32'h0);

        // Buttons 1 and 3 released on the same edge
        applyStimulus(5'b01010, 50, 5);
        checkOutput("coll_short",    32'(seen_short),          32'b01010);
        checkOutput("coll_code",     32'(first_code),          32'd1);
        checkOutput("coll_type",     32'(first_type),          32'b01);
        checkOutput("coll_npulse",   32'(pulse_cycles),        32'd1);
        checkOutput("coll_overflow", 32'(evt_if.evt_overflow), 32'h1);

        doReset();
        checkOutput("rst2_overflow", 32'(evt_if.evt_overflow), 32'h0);

        // Backpressure: btn 4 event stuck pending, btn 0 event dropped
        evt_if.evt_ready = 1'b0;
        applyStimulus(5'b10000, 5, 3);
        checkOutput("bp1_valid",    32'(evt_if.evt_valid),    32'h1);
        checkOutput("bp1_code",     32'(evt_if.evt_code),     32'd4);
        checkOutput("bp1_type",     32'(evt_if.evt_type),     32'b01);
        checkOutput("bp1_overflow", 32'(evt_if.evt_overflow), 32'h0);
        applyStimulus(5'b00001, 5, 3);
        checkOutput("bp2_short",    32'(seen_short),          32'b00001);
        checkOutput("bp2_valid",    32'(evt_if.evt_valid),    32'h1);
        checkOutput("bp2_code",     32'(evt_if.evt_code),     32'd4);
        checkOutput("bp2_type",     32'(evt_if.evt_type),     32'b01);
        checkOutput("bp2_overflow", 32'(evt_if.evt_overflow), 32'h1);
        evt_if.evt_ready = 1'b1;
        tick();
        evt_if.evt_ready = 1'b0;
        checkOutput("bp3_valid",    32'(evt_if.evt_valid),    32'h0);
        evt_if.evt_ready = 1'b1;

        // Reset in the middle of a hold on button 0, button kept pressed throughout
        doReset();
        clearCapture();
        btn_level = 5'b00001;
        for (int k = 0; k < 500; k++) begin
            tick();
            observe(k);
        end
        checkOutput("mid_pre_pulses", 32'(pulse_cycles), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("mid_rst%0d_outs", k),
                        32'({short_pulse, long_pulse, repeat_pulse, evt_if.evt_valid,
                             evt_if.evt_code, evt_if.evt_type, evt_if.evt_overflow}), 32'h0);
        end
        reset = 1'b0;
        clearCapture();
        for (int k = 0; k < LONG_C + 10; k++) begin
            tick();
            observe(k);
        end
        checkOutput("mid_long",    32'(seen_long),  32'b00001);
        checkOutput("mid_long_at", 32'(long_at),    32'(LONG_C));
        checkOutput("mid_short",   32'(seen_short), 32'h0);
        checkOutput("mid_code",    32'(first_code), 32'd0);
        checkOutput("mid_type",    32'(first_type), 32'b10);
        btn_level = '0;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
